// File: rtl/trid_fetch_slot.sv
// ---------------------------------------------------------------------------
// trid_fetch_slot
//
// One transaction-ID slot of the fetch engine (one instance per TRID).
// For each accepted request the slot:
//   1. issues a single AXI-style read burst of r_size beats,
//   2. buffers up to RD_BEATS_MAX beats of read data,
//   3. extracts the byte window [r_start .. r_end] and packs it to byte 0,
//   4. issues a single write burst of w_size beats with the supplied strobes,
//   5. waits for the write response and then reports ready again.
//
// Ports
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_en                  request strobe (honoured only while o_ready = 1)
//   i_r_addr/size         read burst byte address / beat count (1..8)
//   i_r_start/end         inclusive byte window into the read buffer
//   i_w_addr/size         write burst byte address / beat count (1..4)
//   i_w_strb              byte strobes, beat k uses bits [16k+15:16k]
//   o_ready               slot idle
//   o_err                 sticky error (bad descriptor or non-OKAY response)
//   AR / R                read address and read data channels
//   AW / W / B            write address, write data and write response
// ---------------------------------------------------------------------------
module trid_fetch_slot #(
    parameter int ADDR         = 32,
    parameter int BUS_WIDTH    = 16,
    parameter int BUS_BIT      = 7,
    parameter int RD_BEATS_MAX = 8,
    parameter int WR_BEATS_MAX = 4
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,

    input  logic                              i_en,
    input  logic [ADDR-1:0]                   i_r_addr,
    input  logic [4:0]                        i_r_size,
    input  logic [BUS_BIT-1:0]                i_r_start,
    input  logic [BUS_BIT-1:0]                i_r_end,
    input  logic [ADDR-1:0]                   i_w_addr,
    input  logic [4:0]                        i_w_size,
    input  logic [BUS_WIDTH*WR_BEATS_MAX-1:0] i_w_strb,
    output logic                              o_ready,
    output logic                              o_err,

    output logic                              o_ar_valid,
    input  logic                              i_ar_ready,
    output logic [ADDR-1:0]                   o_ar_addr,
    output logic [7:0]                        o_ar_len,

    input  logic                              i_r_valid,
    output logic                              o_r_ready,
    input  logic [BUS_WIDTH*8-1:0]            i_r_data,
    input  logic                              i_r_last,
    input  logic [1:0]                        i_r_resp,

    output logic                              o_aw_valid,
    input  logic                              i_aw_ready,
    output logic [ADDR-1:0]                   o_aw_addr,
    output logic [7:0]                        o_aw_len,

    output logic                              o_w_valid,
    input  logic                              i_w_ready,
    output logic [BUS_WIDTH*8-1:0]            o_w_data,
    output logic [BUS_WIDTH-1:0]              o_w_strb,
    output logic                              o_w_last,

    input  logic                              i_b_valid,
    output logic                              o_b_ready,
    input  logic [1:0]                        i_b_resp
);

    localparam int BEAT_W   = BUS_WIDTH * 8;
    localparam int RD_BYTES = RD_BEATS_MAX * BUS_WIDTH;
    localparam int WR_BYTES = WR_BEATS_MAX * BUS_WIDTH;
    localparam int RD_CNT_W = $clog2(RD_BEATS_MAX);
    localparam int WR_CNT_W = $clog2(WR_BEATS_MAX);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        PACK,
        WR_ADDR,
        WR_DATA,
        WR_RESP
    } state_t;

    state_t                              state;

    logic [ADDR-1:0]                     r_addr_q;
    logic [4:0]                          r_size_q;
    logic [BUS_BIT-1:0]                  r_start_q;
    logic [BUS_BIT-1:0]                  r_end_q;
    logic [ADDR-1:0]                     w_addr_q;
    logic [4:0]                          w_size_q;
    logic [BUS_WIDTH*WR_BEATS_MAX-1:0]   w_strb_q;

    logic [RD_CNT_W-1:0]                 rd_cnt;
    logic [WR_CNT_W-1:0]                 wr_cnt;
    logic [RD_BYTES*8-1:0]               rd_buf;
    logic [WR_BYTES*8-1:0]               wr_buf;

    logic                                desc_ok;
    logic                                rd_done;
    logic [WR_CNT_W-1:0]                 wr_next;
    logic [RD_BYTES*8-1:0]               rd_shift;
    logic [BUS_BIT-1:0]                  span;
    logic [WR_BYTES*8-1:0]               pack_next;

    // A descriptor is rejected outright if either burst length is out of
    // range or the byte window is inverted; nothing is issued in that case.
    assign desc_ok = (i_r_size != 5'd0) && (i_r_size <= 5'(RD_BEATS_MAX)) &&
                     (i_w_size != 5'd0) && (i_w_size <= 5'(WR_BEATS_MAX)) &&
                     (i_r_end >= i_r_start);

    // The read burst ends on whichever comes first: the slave's RLAST or the
    // beat count we asked for.
    assign rd_done = i_r_last || (5'(rd_cnt) == r_size_q - 5'd1);

    assign wr_next = wr_cnt + WR_CNT_W'(1);

    // Address-channel payloads come straight from the latched descriptor, so
    // they are stable for the whole time the matching valid is high.
    assign o_ar_addr = r_addr_q;
    assign o_ar_len  = 8'(r_size_q) - 8'd1;
    assign o_aw_addr = w_addr_q;
    assign o_aw_len  = 8'(w_size_q) - 8'd1;

    // Window extraction: shift the read buffer down by r_start bytes and
    // keep only the first (r_end - r_start + 1) bytes; everything beyond the
    // window, and anything past the write buffer size, is zero.
    always_comb begin
        rd_shift  = rd_buf >> (int'(r_start_q) * 8);
        span      = r_end_q - r_start_q;
        pack_next = '0;
        for (int j = 0; j < WR_BYTES; j++) begin
            if (j <= int'(span)) begin
                pack_next[j*8 +: 8] = rd_shift[j*8 +: 8];
            end
        end
    end

    // Main controller: every handshake output is a register that is set when
    // entering the state that owns it and cleared only on its handshake, so
    // no valid ever drops without being accepted (reset excepted).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            o_ready    <= 1'b1;
            o_err      <= 1'b0;
            o_ar_valid <= 1'b0;
            o_r_ready  <= 1'b0;
            o_aw_valid <= 1'b0;
            o_w_valid  <= 1'b0;
            o_w_data   <= '0;
            o_w_strb   <= '0;
            o_w_last   <= 1'b0;
            o_b_ready  <= 1'b0;
            r_addr_q   <= '0;
            r_size_q   <= '0;
            r_start_q  <= '0;
            r_end_q    <= '0;
            w_addr_q   <= '0;
            w_size_q   <= '0;
            w_strb_q   <= '0;
            rd_cnt     <= '0;
            wr_cnt     <= '0;
            rd_buf     <= '0;
            wr_buf     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_en && o_ready) begin
                        r_addr_q  <= i_r_addr;
                        r_size_q  <= i_r_size;
                        r_start_q <= i_r_start;
                        r_end_q   <= i_r_end;
                        w_addr_q  <= i_w_addr;
                        w_size_q  <= i_w_size;
                        w_strb_q  <= i_w_strb;
                        if (desc_ok) begin
                            // Clear the buffer so a short (early RLAST)
                            // burst leaves the unfilled bytes at zero.
                            rd_buf     <= '0;
                            rd_cnt     <= '0;
                            wr_cnt     <= '0;
                            o_ready    <= 1'b0;
                            o_ar_valid <= 1'b1;
                            state      <= RD_ADDR;
                        end else begin
                            o_err <= 1'b1;
                        end
                    end
                end

                RD_ADDR: begin
                    if (i_ar_ready) begin
                        o_ar_valid <= 1'b0;
                        o_r_ready  <= 1'b1;
                        state      <= RD_DATA;
                    end
                end

                RD_DATA: begin
                    if (i_r_valid) begin
                        rd_buf[int'(rd_cnt)*BEAT_W +: BEAT_W] <= i_r_data;
                        if (i_r_resp != 2'b00) begin
                            o_err <= 1'b1;
                        end
                        if (rd_done) begin
                            o_r_ready <= 1'b0;
                            state     <= PACK;
                        end else begin
                            rd_cnt <= rd_cnt + RD_CNT_W'(1);
                        end
                    end
                end

                PACK: begin
                    wr_buf     <= pack_next;
                    o_aw_valid <= 1'b1;
                    state      <= WR_ADDR;
                end

                WR_ADDR: begin
                    if (i_aw_ready) begin
                        o_aw_valid <= 1'b0;
                        o_w_valid  <= 1'b1;
                        o_w_data   <= wr_buf[0 +: BEAT_W];
                        o_w_strb   <= w_strb_q[0 +: BUS_WIDTH];
                        o_w_last   <= (w_size_q == 5'd1);
                        wr_cnt     <= '0;
                        state      <= WR_DATA;
                    end
                end

                WR_DATA: begin
                    // The next beat is preloaded on each handshake so the
                    // bus holds steady for as long as WREADY stays low.
                    if (i_w_ready) begin
                        if (o_w_last) begin
                            o_w_valid <= 1'b0;
                            o_w_last  <= 1'b0;
                            o_b_ready <= 1'b1;
                            state     <= WR_RESP;
                        end else begin
                            wr_cnt   <= wr_next;
                            o_w_data <= wr_buf[int'(wr_next)*BEAT_W +: BEAT_W];
                            o_w_strb <= w_strb_q[int'(wr_next)*BUS_WIDTH +: BUS_WIDTH];
                            o_w_last <= (5'(wr_next) == w_size_q - 5'd1);
                        end
                    end
                end

                WR_RESP: begin
                    if (i_b_valid) begin
                        if (i_b_resp != 2'b00) begin
                            o_err <= 1'b1;
                        end
                        o_b_ready <= 1'b0;
                        o_ready   <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
